// File: rtl/mem_arb_ctrl_if.sv
// Bundle of requester, response and memory-command signals for mem_arb_ctrl.
// The master modport is the arbiter; the slave modport is the requesters plus memory.
interface mem_arb_ctrl_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic [1:0]              req_valid;
    logic [1:0]              req_wr_rd;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*WIDTH-1:0]      req_wdata;
    logic [1:0]              req_ready;
    logic [1:0]              rsp_valid;
    logic [WIDTH-1:0]        rsp_rdata;
    logic                    rsp_err;
    logic                    mem_valid;
    logic                    mem_wr_rd;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WIDTH-1:0]        mem_wdata;
    logic [WIDTH-1:0]        mem_rdata;
    logic                    mem_ready;
    logic                    busy;

    modport master (
        input  req_valid, req_wr_rd, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_valid, mem_wr_rd, mem_addr, mem_wdata, busy
    );

    modport slave (
        output req_valid, req_wr_rd, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_valid, mem_wr_rd, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Two-requester arbiter/sequencer in front of one single-port memory, with ready timeout.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mem_arb_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 40,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned TIMEOUT    = 15
) (
    input logic            clk,
    input logic            rst,
    mem_arb_ctrl_if.master bus
);
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  winner_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [1:0]            rsp_valid_q;
    logic [WIDTH-1:0]      rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  mem_valid_q;
    logic                  mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_wdata_q;

    logic                  pick;
    logic                  any_req;
    logic                  sel_wr_rd;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic [1:0]            winner_onehot;

    assign any_req = |bus.req_valid;

`ifdef ARB_FIXED_PRIO_EN
    assign pick = ~bus.req_valid[0];
`else
    logic rr_ptr_q;

    // With a single requester the valid bit alone decides; rr_ptr only breaks ties.
    assign pick = (&bus.req_valid) ? rr_ptr_q : bus.req_valid[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (state_q == RESP) begin
            rr_ptr_q <= ~winner_q;
        end
    end
`endif

    assign sel_wr_rd     = pick ? bus.req_wr_rd[1] : bus.req_wr_rd[0];
    assign sel_addr      = pick ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : bus.req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata     = pick ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
    assign winner_onehot = winner_q ? 2'b10 : 2'b01;
    assign cnt_inc       = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.mem_ready || cnt_inc == CNT_LIMIT) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            winner_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        winner_q    <= pick;
                        mem_valid_q <= 1'b1;
                        mem_wr_rd_q <= sel_wr_rd;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                    end
                end
                ISSUE: begin
                    mem_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
                WAIT: begin
                    if (bus.mem_ready) begin
                        rsp_valid_q <= winner_onehot;
                        rsp_rdata_q <= mem_wr_rd_q ? '0 : bus.mem_rdata;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_LIMIT) begin
                            rsp_valid_q <= winner_onehot;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    rsp_valid_q <= 2'b00;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE && !rst && any_req) ? (pick ? 2'b10 : 2'b01)
                                                                 : 2'b00;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_wr_rd = mem_wr_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: reset, write/read, arbitration, timeout, mid-op reset.
// A small memory responder answers one cycle after each command unless stalled.
module tb_mem_arb_ctrl;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 40;
    localparam int unsigned AW      = 6;
    localparam int unsigned TIMEOUT = 15;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_stuck;
    logic [7:0] mem [64];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arb_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

    mem_arb_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory contents start as 0x10 + address; writes return junk data so the DUT must zero it.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h10 + 8'(i);
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= 8'h00;
        end else if (bus.mem_valid && !mem_stuck) begin
            if (bus.mem_wr_rd) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= bus.mem_wr_rd ? 8'h5A : mem[bus.mem_addr];
            bus.mem_ready <= 1'b1;
        end else begin
            bus.mem_ready <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic run_txn(input string tag, input logic [1:0] valid, input logic [1:0] wr,
                           input logic [5:0] a0, input logic [5:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [1:0] exp_grant, input logic [7:0] exp_rdata,
                           input logic exp_err, input int exp_lat);
        logic sel;
        int lat;
        sel = exp_grant[1];
        bus.req_valid = valid;
        bus.req_wr_rd = wr;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        #1;
        check_eq({tag, ".grant"}, 32'(bus.req_ready), 32'(exp_grant));
        check_eq({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        tick;
        bus.req_valid = valid & ~exp_grant;
        #1;
        check_eq({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd1);
        check_eq({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(sel ? a1 : a0));
        check_eq({tag, ".mem_wr_rd"}, 32'(bus.mem_wr_rd), 32'(wr[sel]));
        if (wr[sel]) check_eq({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(sel ? d1 : d0));
        check_eq({tag, ".issue_ready"}, 32'(bus.req_ready), 32'd0);
        tick;
        check_eq({tag, ".wait_mem_valid"}, 32'(bus.mem_valid), 32'd0);
        lat = 2;
        do begin
            tick;
            lat++;
        end while (bus.rsp_valid == 2'b00 && lat < 40);
        check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_grant));
        check_eq({tag, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
        check_eq({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        tick;
        check_eq({tag, ".rsp_clear"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, ".err_clear"}, 32'(bus.rsp_err), 32'd0);
        check_eq({tag, ".back_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] g;
        rst           = 1'b1;
        mem_stuck     = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_wr_rd = 2'b00;
        bus.req_addr  = {6'd1, 6'd0};
        bus.req_wdata = 16'h0;
        tick;
        tick;
        check_eq("rst.req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst.mem_valid", 32'(bus.mem_valid), 32'd0);
        check_eq("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst.rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check_eq("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("rst.mem_wr_rd", 32'(bus.mem_wr_rd), 32'd0);
        check_eq("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check_eq("rst.busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // First arbitration after reset goes to requester 0.
        run_txn("first", 2'b11, 2'b00, 6'd0, 6'd1, 8'h00, 8'h00, 2'b01, 8'h10, 1'b0, 3);

        // Write then read back through the other requester.
        run_txn("wr0", 2'b01, 2'b01, 6'd3, 6'd0, 8'hA5, 8'h00, 2'b01, 8'h00, 1'b0, 3);
        run_txn("rd1", 2'b10, 2'b00, 6'd0, 6'd3, 8'h00, 8'h00, 2'b10, 8'hA5, 1'b0, 3);

        // Both continuously requesting: round-robin alternates, fixed priority keeps 0.
        for (int i = 0; i < 6; i++) begin
            g = (FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10;
            run_txn($sformatf("rr%0d", i), 2'b11, 2'b00, 6'd5, 6'd6, 8'h00, 8'h00,
                    g, g[1] ? 8'h16 : 8'h15, 1'b0, 3);
        end

        // Stalled memory: error response after TIMEOUT wait cycles, then normal service.
        mem_stuck = 1'b1;
        run_txn("tmo", 2'b01, 2'b00, 6'd7, 6'd0, 8'h00, 8'h00, 2'b01, 8'h00, 1'b1,
                2 + TIMEOUT);
        mem_stuck = 1'b0;
        run_txn("after_tmo", 2'b10, 2'b00, 6'd0, 6'd7, 8'h00, 8'h00, 2'b10, 8'h17, 1'b0, 3);

        // Reset in WAIT: transaction dropped, pointer back to requester 0.
        run_txn("pre_rst", 2'b01, 2'b00, 6'd2, 6'd0, 8'h00, 8'h00, 2'b01, 8'h12, 1'b0, 3);
        mem_stuck     = 1'b1;
        bus.req_valid = 2'b10;
        bus.req_addr  = {6'd4, 6'd0};
        #1;
        check_eq("mid.grant", 32'(bus.req_ready), 32'd2);
        tick;
        tick;
        tick;
        check_eq("mid.in_wait", 32'(bus.busy), 32'd1);
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        tick;
        check_eq("mid.busy", 32'(bus.busy), 32'd0);
        check_eq("mid.req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("mid.mem_valid", 32'(bus.mem_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("mid.no_rsp%0d", i), 32'(bus.rsp_valid), 32'd0);
            tick;
        end
        rst       = 1'b0;
        mem_stuck = 1'b0;
        run_txn("post_rst", 2'b11, 2'b00, 6'd8, 6'd9, 8'h00, 8'h00, 2'b01, 8'h18, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
